// File: rtl/nist_pkg.sv
// Shared constants, readout selector encodings and FSM state type for the
// NIST SP 800-22 randomness monitor (Frequency/monobit and Runs tests).
package nist_pkg;

   localparam int N_LOG2     = 10;
   localparam int W          = N_LOG2 + 1;   // holds counts up to N inclusive
   localparam int N          = 1 << N_LOG2;
   localparam int HI_W       = W - 8;        // width of the upper readout slice
   localparam int MONO_THR   = 82;           // |2*ones - N| <= MONO_THR
   localparam int PREREQ_THR = 64;           // |ones - N/2| <  PREREQ_THR
   localparam int RUNS_THR   = 41;           // |V - N/2|    <= RUNS_THR

   localparam logic [2:0] SEL_ONES_LO = 3'd0;
   localparam logic [2:0] SEL_ONES_HI = 3'd1;
   localparam logic [2:0] SEL_RUNS_LO = 3'd2;
   localparam logic [2:0] SEL_RUNS_HI = 3'd3;
   localparam logic [2:0] SEL_LONG_LO = 3'd4;
   localparam logic [2:0] SEL_LONG_HI = 3'd5;
   localparam logic [2:0] SEL_STATUS  = 3'd6;
   localparam logic [2:0] SEL_BITCNT  = 3'd7;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_DONE    = 1'b1
   } state_t;

   // Magnitude of a signed verdict difference (W+2 bits wide).
   function automatic logic [W+1:0] abs_s(input logic signed [W+1:0] x);
      return (x < 0) ? -x : x;
   endfunction

endpackage

// File: rtl/nist_stream_stats.sv
// Bit-stream statistics accumulator.
// Ports:
//   clk, rst      - clock, async active-high reset
//   clr           - synchronous clear of every counter (wins over accept)
//   accept, bit_in- one accepted stream bit per asserted cycle
//   bit_cnt, ones, runs, longest - registered counts
//   ones_nxt, runs_nxt - counts including the bit being accepted this cycle,
//                        used to evaluate verdicts on the block's final edge
module nist_stream_stats
   import nist_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         accept,
   input  logic         bit_in,
   output logic [W-1:0] bit_cnt,
   output logic [W-1:0] ones,
   output logic [W-1:0] runs,
   output logic [W-1:0] longest,
   output logic [W-1:0] ones_nxt,
   output logic [W-1:0] runs_nxt
);

   logic [W-1:0] cur_run;
   logic [W-1:0] cur_run_nxt;
   logic [W-1:0] longest_nxt;
   logic         prev_bit;

   always_comb begin
      ones_nxt    = ones + W'(bit_in);
      // The first bit of a block opens the first run.
      runs_nxt    = (bit_cnt == '0) ? W'(1) : runs + W'(bit_in != prev_bit);
      cur_run_nxt = bit_in ? cur_run + W'(1) : '0;
      longest_nxt = (cur_run_nxt > longest) ? cur_run_nxt : longest;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt  <= '0;
         ones     <= '0;
         runs     <= '0;
         cur_run  <= '0;
         longest  <= '0;
         prev_bit <= 1'b0;
      end else if (clr) begin
         bit_cnt  <= '0;
         ones     <= '0;
         runs     <= '0;
         cur_run  <= '0;
         longest  <= '0;
         prev_bit <= 1'b0;
      end else if (accept) begin
         bit_cnt  <= bit_cnt + W'(1);
         ones     <= ones_nxt;
         runs     <= runs_nxt;
         cur_run  <= cur_run_nxt;
         longest  <= longest_nxt;
         prev_bit <= bit_in;
      end
   end

endmodule

// File: rtl/nist_randomness_monitor.sv
// Tiny Tapeout top: runs the monobit and runs tests over 2^N_LOG2-bit blocks.
// Ports:
//   clk, rst  - clock, async active-high reset
//   ena       - design selected; gates bit_valid and start
//   ui_in     - [0] bit_in, [1] bit_valid, [2] start, [5:3] rd_sel
//   uio_in    - unused
//   uo_out    - readout byte chosen by rd_sel
//   uio_out   - [0] done, [1] mono_pass, [2] runs_pass, [3] prereq_ok, [4] busy
//   uio_oe    - all bidirectional pins driven as outputs
//
// state      | meaning
// ST_COLLECT | accumulating stream bits, busy = 1
// ST_DONE    | block complete, counts and verdicts frozen, done = 1
module nist_randomness_monitor
   import nist_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   state_t state, state_nxt;

   logic         bit_in, bit_valid, start_pin;
   logic [2:0]   rd_sel;
   logic         clr, accept, last_bit;
   logic         busy, done;
   logic         mono_pass, runs_pass, prereq_ok;
   logic         mono_ok, runs_ok, prereq_ok_nxt;
   logic [W-1:0] bit_cnt, ones, runs, longest, ones_nxt, runs_nxt;
   logic [4:0]   status;
   logic         unused_pins;

   logic signed [W+1:0] mono_diff, prereq_diff, runs_diff;

   assign bit_in    = ui_in[0];
   assign bit_valid = ui_in[1];
   assign start_pin = ui_in[2];
   assign rd_sel    = ui_in[5:3];
   assign unused_pins = &{1'b0, uio_in, ui_in[7:6]};

   // start wins over a simultaneous valid bit, which is dropped.
   assign clr      = ena & start_pin;
   assign accept   = ena & bit_valid & ~start_pin & (state == ST_COLLECT);
   assign last_bit = accept & (bit_cnt == W'(N - 1));

   nist_stream_stats u_stats (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .accept   (accept),
      .bit_in   (bit_in),
      .bit_cnt  (bit_cnt),
      .ones     (ones),
      .runs     (runs),
      .longest  (longest),
      .ones_nxt (ones_nxt),
      .runs_nxt (runs_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr)           state_nxt = ST_COLLECT;
      else if (last_bit) state_nxt = ST_DONE;
   end

   always_comb begin
      busy = (state == ST_COLLECT);
      done = (state == ST_DONE);
   end

   // Verdicts evaluated on the counts that include the final bit.
   always_comb begin
      mono_diff     = $signed({1'b0, ones_nxt, 1'b0}) - $signed((W+2)'(N));
      prereq_diff   = $signed({2'b00, ones_nxt}) - $signed((W+2)'(N / 2));
      runs_diff     = $signed({2'b00, runs_nxt}) - $signed((W+2)'(N / 2));
      mono_ok       = abs_s(mono_diff) <= (W+2)'(MONO_THR);
      prereq_ok_nxt = abs_s(prereq_diff) < (W+2)'(PREREQ_THR);
      runs_ok       = prereq_ok_nxt & (abs_s(runs_diff) <= (W+2)'(RUNS_THR));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mono_pass <= 1'b0;
         runs_pass <= 1'b0;
         prereq_ok <= 1'b0;
      end else if (clr) begin
         mono_pass <= 1'b0;
         runs_pass <= 1'b0;
         prereq_ok <= 1'b0;
      end else if (last_bit) begin
         mono_pass <= mono_ok;
         runs_pass <= runs_ok;
         prereq_ok <= prereq_ok_nxt;
      end
   end

   assign status  = {busy, prereq_ok, runs_pass, mono_pass, done};
   assign uio_out = {3'b000, status};
   assign uio_oe  = 8'hFF;

   always_comb begin
      uo_out = 8'h00;
      case (rd_sel)
         SEL_ONES_LO: uo_out = ones[7:0];
         SEL_ONES_HI: uo_out = {{(8-HI_W){1'b0}}, ones[W-1:8]};
         SEL_RUNS_LO: uo_out = runs[7:0];
         SEL_RUNS_HI: uo_out = {{(8-HI_W){1'b0}}, runs[W-1:8]};
         SEL_LONG_LO: uo_out = longest[7:0];
         SEL_LONG_HI: uo_out = {{(8-HI_W){1'b0}}, longest[W-1:8]};
         SEL_STATUS:  uo_out = {3'b000, status};
         SEL_BITCNT:  uo_out = bit_cnt[7:0];
         default:     uo_out = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_nist_randomness_monitor.sv
module tb_nist_randomness_monitor;

   localparam int NB = 1024;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   logic       bit_in, valid, start;
   logic [2:0] rd_sel;

   assign ui_in = {2'b00, rd_sel, start, valid, bit_in};

   nist_randomness_monitor dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   bit blk [NB];
   int m_ones, m_v, m_long;
   bit m_mono, m_pre, m_runs;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
   endtask

   task automatic read_sel(input logic [2:0] s, output logic [7:0] v);
      rd_sel = s;
      #1;
      v = uo_out;
   endtask

   // Reference statistics straight from the test definitions.
   task automatic model_block();
      int run;
      int d;
      m_ones = 0;
      m_v = 1;
      m_long = 0;
      run = 0;
      for (int i = 0; i < NB; i++) begin
         m_ones += int'(blk[i]);
         if (i > 0 && blk[i] != blk[i-1]) m_v++;
         run = blk[i] ? run + 1 : 0;
         if (run > m_long) m_long = run;
      end
      d = 2 * m_ones - NB;
      m_mono = (d < 0 ? -d : d) <= 82;
      d = m_ones - NB / 2;
      m_pre = (d < 0 ? -d : d) < 64;
      d = m_v - NB / 2;
      m_runs = m_pre && ((d < 0 ? -d : d) <= 41);
   endtask

   task automatic check_results(input string tag);
      logic [7:0] v;
      logic [7:0] exp [8];
      logic [7:0] st;
      st = {3'b000, 1'b0, m_pre, m_runs, m_mono, 1'b1};
      exp[0] = 8'(m_ones % 256);
      exp[1] = 8'(m_ones / 256);
      exp[2] = 8'(m_v % 256);
      exp[3] = 8'(m_v / 256);
      exp[4] = 8'(m_long % 256);
      exp[5] = 8'(m_long / 256);
      exp[6] = st;
      exp[7] = 8'(NB % 256);
      for (int s = 0; s < 8; s++) begin
         read_sel(3'(s), v);
         check($sformatf("%s_sel%0d", tag, s), v, exp[s]);
      end
      check({tag, "_uio_out"}, uio_out, st);
      check({tag, "_uio_oe"}, uio_oe, 8'hFF);
   endtask

   task automatic run_block();
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         bit_in = blk[i];
         valid  = 1'b1;
      end
      @(negedge clk);
      valid  = 1'b0;
      bit_in = 1'b0;
   endtask

   task automatic rand_block(input int pct_ones);
      for (int i = 0; i < NB; i++) blk[i] = ($urandom_range(0, 99) < pct_ones);
   endtask

   initial begin
      logic [7:0] v;
      logic [15:0] lfsr;
      rst = 1'b1; ena = 1'b1; uio_in = 8'h00;
      bit_in = 1'b0; valid = 1'b0; start = 1'b0; rd_sel = 3'd0;

      // Reset / idle
      #17 rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 8; s++) begin
         read_sel(3'(s), v);
         check($sformatf("reset_sel%0d", s), v, (s == 6) ? 8'h10 : 8'h00);
      end
      check("reset_uio_out", uio_out, 8'h10);
      check("reset_uio_oe", uio_oe, 8'hFF);

      // All ones
      for (int i = 0; i < NB; i++) blk[i] = 1'b1;
      run_block(); model_block();
      check_results("ones");
      check("ones_flags", uio_out, 8'h01);

      // Alternating, starting with 1
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < NB; i++) blk[i] = (i % 2 == 0);
      run_block(); model_block();
      check_results("alt");
      check("alt_flags", uio_out, 8'h0B);

      // LFSR x^16+x^14+x^13+x^11+1, seed ACE1
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      lfsr = 16'hACE1;
      for (int i = 0; i < NB; i++) begin
         blk[i] = lfsr[0];
         lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
      run_block(); model_block();
      check_results("lfsr");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bit_in = 1'($urandom_range(0, 1));
         valid  = 1'b1;
      end
      @(negedge clk); valid = 1'b0;
      check_results("lfsr_hold");

      // start collides with a valid bit at bit 500
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      rand_block(50);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         bit_in = blk[i];
         valid  = 1'b1;
      end
      @(negedge clk); bit_in = 1'b1; valid = 1'b1; start = 1'b1;
      @(negedge clk); valid = 1'b0; start = 1'b0;
      read_sel(3'd7, v);
      check("start_bitcnt", v, 8'h00);
      read_sel(3'd0, v);
      check("start_ones", v, 8'h00);
      check("start_busy", uio_out, 8'h10);
      rand_block(50);
      run_block(); model_block();
      check_results("fresh");

      // Async reset between edges at bit 300
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      rand_block(50);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         bit_in = blk[i];
         valid  = 1'b1;
      end
      @(negedge clk); valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_bitcnt_now", uo_out, 8'h00);
      for (int s = 0; s < 8; s++) begin
         read_sel(3'(s), v);
         check($sformatf("rst_sel%0d", s), v, (s == 6) ? 8'h10 : 8'h00);
      end
      @(negedge clk); rst = 1'b0;

      // ena low: nothing accepted
      ena = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         valid  = ~valid;
         bit_in = 1'($urandom_range(0, 1));
      end
      @(negedge clk); valid = 1'b0; ena = 1'b1;
      read_sel(3'd7, v);
      check("ena_off_bitcnt", v, 8'h00);
      read_sel(3'd0, v);
      check("ena_off_ones", v, 8'h00);

      // Biased random block, then start from DONE
      rand_block(55);
      run_block(); model_block();
      check_results("biased");
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("restart_flags", uio_out, 8'h10);
      read_sel(3'd2, v);
      check("restart_runs", v, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
